uart_rx: RTL and testbench

Serial receiver paired with the board's UART transmitter. It deserialises an 8N1 stream (from the ESP32, or looped back from the transmitter's serial output) into bytes. Each valid byte is presented with a one-cycle strobe for the seven-segment display path and for downstream logic. It runs on the 50 MHz board clock, and the bit timing comes from a clocks-per-bit parameter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board UART (receiver and transmitter).
//   DATA_BITS            : payload bits per frame
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud, shared with the transmitter
//   rx_state_e           : receiver state encoding
// ---------------------------------------------------------------------------
package uart_pkg;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      CLEANUP,
      BREAK
   } rx_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for asynchronous inputs; both stages reset to 1 so an
// idle-high serial line does not look like a start bit coming out of reset.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   async_i : asynchronous input bus
//   sync_o  : synchronised output (two clocks of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. Samples each bit at its centre, delivers bytes with a
// one-cycle o_RX_DV strobe and flags bad stop bits with o_Frame_Err. A line
// held low after a bad stop bit is parked in BREAK so it yields a single
// frame error and no phantom bytes.
// Optional macro UART_RX_PARITY_EN: adds an even-parity bit after data bit 7
// and drives o_Parity_Err; otherwise o_Parity_Err is tied low.
// Ports:
//   clk          : 50 MHz board clock
//   rst          : synchronous active-high reset
//   i_RX_Serial  : asynchronous serial line, idle high
//   o_RX_DV      : one-cycle strobe, o_RX_Byte holds a new byte
//   o_RX_Byte    : last correctly framed byte
//   o_RX_Active  : high from start-bit detect until back in IDLE
//   o_Frame_Err  : one-cycle strobe, stop bit sampled low
//   o_Parity_Err : one-cycle strobe alongside o_RX_DV on parity mismatch
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Active,
   output logic       o_Frame_Err,
   output logic       o_Parity_Err
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q;
   logic [CW-1:0]        cnt_q;
   logic [2:0]           idx_q;
   logic [DATA_BITS-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q;
`endif

   uart_rx_sync #(.WIDTH(1)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (i_RX_Serial),
      .sync_o  (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         o_RX_DV     <= 1'b0;
         o_RX_Byte   <= 8'h00;
         o_RX_Active <= 1'b0;
         o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         o_Parity_Err <= 1'b0;
`endif
      end else begin
         // Strobes default low so they can only ever last one cycle.
         o_RX_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_Parity_Err <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q     <= START;
                  o_RX_Active <= 1'b1;
               end
            end
            // Half-bit wait puts every later sample at a bit centre.
            START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  if (!rx_s) begin
                     state_q <= DATA;
                  end else begin
                     state_q     <= IDLE;
                     o_RX_Active <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  par_bit_q <= rx_s;
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= CLEANUP;
                  if (rx_s) begin
                     o_RX_Byte <= shift_q;
                     o_RX_DV   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     // Even parity: data XOR parity bit must be zero.
                     o_Parity_Err <= (^shift_q) ^ par_bit_q;
`endif
                  end else begin
                     o_Frame_Err <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CLEANUP: begin
               if (rx_s) begin
                  state_q     <= IDLE;
                  o_RX_Active <= 1'b0;
               end else begin
                  state_q <= BREAK;
               end
            end
            // Line still low after the stop bit: wait it out silently.
            BREAK: begin
               if (rx_s) begin
                  state_q     <= IDLE;
                  o_RX_Active <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               o_RX_Active <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign o_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Randomised scoreboard bench for uart_rx. The stimulus side builds each
// frame from plain bit lists and queues the expected receiver response; a
// monitor pops and compares whenever the DUT strobes.
// Honours UART_RX_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_uart_rx;
   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_Frame_Err;
   logic       o_Parity_Err;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit         is_fe;
      logic [7:0] data;
      bit         pe;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] last_good = 8'h00;
   logic       strobe_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_RX_Serial  (rx),
      .o_RX_DV      (o_RX_DV),
      .o_RX_Byte    (o_RX_Byte),
      .o_RX_Active  (o_RX_Active),
      .o_Frame_Err  (o_Frame_Err),
      .o_Parity_Err (o_Parity_Err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // One bit-time on the line; entered and left 1 ns after a rising edge.
   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
      exp_t e;
      if (stop) begin
         e.is_fe = 1'b0;
         e.data  = d;
`ifdef UART_RX_PARITY_EN
         e.pe    = ((^d) != par);
`else
         e.pe    = 1'b0;
`endif
         last_good = d;
      end else begin
         e.is_fe = 1'b1;
         e.data  = last_good;
         e.pe    = 1'b0;
      end
      exp_q.push_back(e);
      $display("tx byte=%02h stop=%0b par=%0b", d, stop, par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`endif
      send_bit(stop);
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (rst) begin
         strobe_prev <= 1'b0;
      end else begin
         if (o_RX_DV || o_Frame_Err || o_Parity_Err) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_strobe: dv=%0b fe=%0b pe=%0b byte=%02h, expected no strobe",
                        o_RX_DV, o_Frame_Err, o_Parity_Err, o_RX_Byte);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (o_RX_DV !== !e.is_fe || o_Frame_Err !== e.is_fe ||
                   o_Parity_Err !== e.pe || o_RX_Byte !== e.data || strobe_prev) begin
                  n_err++;
                  $display("FAIL rx_event: got dv=%0b fe=%0b pe=%0b byte=%02h wide=%0b, expected dv=%0b fe=%0b pe=%0b byte=%02h wide=0",
                           o_RX_DV, o_Frame_Err, o_Parity_Err, o_RX_Byte, strobe_prev,
                           !e.is_fe, e.is_fe, e.pe, e.data);
               end else begin
                  $display("rx dv=%0b fe=%0b pe=%0b byte=%02h ok", o_RX_DV, o_Frame_Err, o_Parity_Err, o_RX_Byte);
               end
            end
         end
         strobe_prev <= o_RX_DV || o_Frame_Err || o_Parity_Err;
      end
   end

   initial begin
      int act;
      logic [7:0] d;
      logic stop;

      repeat (4) @(posedge clk);
      #1;
      check("reset_dv",     {31'd0, o_RX_DV},      32'd0);
      check("reset_byte",   {24'd0, o_RX_Byte},    32'd0);
      check("reset_active", {31'd0, o_RX_Active},  32'd0);
      check("reset_fe",     {31'd0, o_Frame_Err},  32'd0);
      check("reset_pe",     {31'd0, o_Parity_Err}, 32'd0);
      rst = 1'b0;
      idle_bits(2);

      // Basic byte, then line idle long enough for o_RX_Active to drop.
      send_frame(8'hA5, 1'b1, even_par(8'hA5));
      idle_bits(1);
      check("active_after_frame", {31'd0, o_RX_Active}, 32'd0);
      check("byte_a5_held", {24'd0, o_RX_Byte}, 32'h0000_00A5);

      // Two-clock glitch: START rejects it, short Active pulse only.
      rx = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rx = 1'b1;
      act = 0;
      repeat (20) begin
         @(negedge clk);
         act += int'(o_RX_Active);
      end
      check("glitch_active_seen", {31'd0, (act > 0)},  32'd1);
      check("glitch_active_short", {31'd0, (act <= 7)}, 32'd1);
      idle_bits(1);

      // Bad stop bit followed by a long break, then a clean byte.
      send_frame(8'h3C, 1'b0, even_par(8'h3C));
      rx = 1'b0;
      repeat (20 * CPB) @(posedge clk);
      #1;
      check("break_byte_held", {24'd0, o_RX_Byte}, 32'h0000_00A5);
      check("break_active", {31'd0, o_RX_Active}, 32'd1);
      idle_bits(2);
      send_frame(8'h55, 1'b1, even_par(8'h55));
      idle_bits(1);

      // Back-to-back with no idle gap.
      send_frame(8'h00, 1'b1, even_par(8'h00));
      send_frame(8'hFF, 1'b1, even_par(8'hFF));
      idle_bits(2);

      // Reset during data bit 4 of 8'hF0.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rx  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_dv",     {31'd0, o_RX_DV},     32'd0);
      check("midrst_byte",   {24'd0, o_RX_Byte},   32'd0);
      check("midrst_active", {31'd0, o_RX_Active}, 32'd0);
      check("midrst_fe",     {31'd0, o_Frame_Err}, 32'd0);
      rst = 1'b0;
      last_good = 8'h00;
      idle_bits(6);
      send_frame(8'h0F, 1'b1, even_par(8'h0F));
      idle_bits(1);

`ifdef UART_RX_PARITY_EN
      // Wrong parity: byte still delivered, parity error alongside.
      send_frame(8'h07, 1'b1, 1'b0);
      idle_bits(1);
`endif

      // Randomised frames with occasional bad stop bits and parity errors.
      for (int n = 0; n < 30; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         send_frame(d, stop, even_par(d) ^ ($urandom_range(0, 3) == 0));
         if (!stop) idle_bits(1 + $urandom_range(0, 1));
         else       idle_bits($urandom_range(0, 2));
      end

      idle_bits(3);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
